// File: rtl/ft601_fifo_responder.sv
// FT601 245-synchronous FIFO chip model: answers an FPGA bus master from an RX buffer
// fed by a local host port, and captures master writes into a TX buffer drained locally.
module ft601_fifo_responder #(
  parameter int LGDEPTH = 4,
  parameter int DW      = 32
) (
  input  logic                   i_ftdi_clk,
  input  logic                   i_reset_n,
  input  logic                   i_ftdi_wr_n,
  input  logic                   i_ftdi_rd_n,
  input  logic                   i_ftdi_oe_n,
  input  logic [DW-1:0]          i_ftdi_data,
  input  logic [DW/8-1:0]        i_ftdi_be,
  output logic [DW-1:0]          o_ftdi_data,
  output logic                   o_ftdi_data_oe,
  output logic                   o_ftdi_rxf_n,
  output logic                   o_ftdi_txe_n,
  input  logic                   i_host_wr,
  input  logic [DW-1:0]          i_host_data,
  output logic                   o_host_full,
  input  logic                   i_host_rd,
  output logic [DW+DW/8-1:0]     o_host_data,
  output logic                   o_host_empty,
  output logic [LGDEPTH:0]       o_rx_count,
  output logic [LGDEPTH:0]       o_tx_count,
  output logic                   o_protocol_err
);

  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << LGDEPTH;
  localparam logic [LGDEPTH:0] PTR_ONE  = {{LGDEPTH{1'b0}}, 1'b1};
  localparam logic [LGDEPTH:0] PTR_ZERO = {(LGDEPTH+1){1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RX_TURN  = 2'd1,
    ST_RX_BURST = 2'd2,
    ST_TX_BURST = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0]    rx_mem [0:DEPTH-1];
  logic [DW+BW-1:0] tx_mem [0:DEPTH-1];

  logic [LGDEPTH:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [LGDEPTH:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [LGDEPTH:0] rx_count_q, rx_count_d, tx_count_q, tx_count_d;
  logic             rxf_n_q, rxf_n_d, txe_n_q, txe_n_d;
  logic             host_full_q, host_full_d, host_empty_q, host_empty_d;
  logic             proto_err_q, proto_err_d;

  logic proto_viol, rx_push, rx_pop, tx_push, tx_pop;

  // Transfer qualification; any protocol violation suppresses the bus transfer that cycle.
  always_comb begin
    proto_viol = (!i_ftdi_rd_n && !i_ftdi_wr_n) ||
                 (!i_ftdi_rd_n &&  i_ftdi_oe_n) ||
                 (!i_ftdi_wr_n && !i_ftdi_oe_n) ||
                 (!i_ftdi_rd_n && (state_q == ST_RX_TURN));
    rx_push = i_host_wr && !host_full_q;
    rx_pop  = !i_ftdi_rd_n && !i_ftdi_oe_n && !rxf_n_q &&
              (state_q == ST_RX_BURST) && !proto_viol;
    tx_push = !i_ftdi_wr_n && !txe_n_q &&
              ((state_q == ST_IDLE) || (state_q == ST_TX_BURST)) && !proto_viol;
    tx_pop  = i_host_rd && !host_empty_q;
  end

  // Pointer, occupancy and flag update; flags reflect post-update occupancy.
  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    if (rx_push) rx_wptr_d = rx_wptr_q + PTR_ONE;
    else         rx_wptr_d = rx_wptr_q;
    if (rx_pop)  rx_rptr_d = rx_rptr_q + PTR_ONE;
    else         rx_rptr_d = rx_rptr_q;
    if (tx_push) tx_wptr_d = tx_wptr_q + PTR_ONE;
    else         tx_wptr_d = tx_wptr_q;
    if (tx_pop)  tx_rptr_d = tx_rptr_q + PTR_ONE;
    else         tx_rptr_d = tx_rptr_q;

    rx_count_d   = rx_wptr_d - rx_rptr_d;
    tx_count_d   = tx_wptr_d - tx_rptr_d;
    rxf_n_d      = (rx_count_d == PTR_ZERO);
    host_full_d  = (rx_wptr_d[LGDEPTH] != rx_rptr_d[LGDEPTH]) &&
                   (rx_wptr_d[LGDEPTH-1:0] == rx_rptr_d[LGDEPTH-1:0]);
    txe_n_d      = (tx_wptr_d[LGDEPTH] != tx_rptr_d[LGDEPTH]) &&
                   (tx_wptr_d[LGDEPTH-1:0] == tx_rptr_d[LGDEPTH-1:0]);
    host_empty_d = (tx_wptr_d == tx_rptr_d);
    proto_err_d  = proto_err_q || proto_viol;
  end

  // Bus-ownership state machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!i_ftdi_wr_n)                  state_d = ST_TX_BURST;
        else if (!i_ftdi_oe_n && !rxf_n_q) state_d = ST_RX_TURN;
        else                               state_d = ST_IDLE;
      end
      ST_RX_TURN: begin
        if (!i_ftdi_oe_n) state_d = ST_RX_BURST;
        else              state_d = ST_IDLE;
      end
      ST_RX_BURST: begin
        if (i_ftdi_oe_n || rxf_n_q) state_d = ST_IDLE;
        else                        state_d = ST_RX_BURST;
      end
      ST_TX_BURST: begin
        if (i_ftdi_wr_n) state_d = ST_IDLE;
        else             state_d = ST_TX_BURST;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge i_ftdi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      rx_wptr_q    <= PTR_ZERO;
      rx_rptr_q    <= PTR_ZERO;
      tx_wptr_q    <= PTR_ZERO;
      tx_rptr_q    <= PTR_ZERO;
      rx_count_q   <= PTR_ZERO;
      tx_count_q   <= PTR_ZERO;
      rxf_n_q      <= 1'b1;
      txe_n_q      <= 1'b0;
      host_full_q  <= 1'b0;
      host_empty_q <= 1'b1;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_wptr_q    <= rx_wptr_d;
      rx_rptr_q    <= rx_rptr_d;
      tx_wptr_q    <= tx_wptr_d;
      tx_rptr_q    <= tx_rptr_d;
      rx_count_q   <= rx_count_d;
      tx_count_q   <= tx_count_d;
      rxf_n_q      <= rxf_n_d;
      txe_n_q      <= txe_n_d;
      host_full_q  <= host_full_d;
      host_empty_q <= host_empty_d;
      proto_err_q  <= proto_err_d;
    end
  end

  // Buffer storage; contents need no reset since pointers define validity.
  always_ff @(posedge i_ftdi_clk) begin
    if (rx_push) rx_mem[rx_wptr_q[LGDEPTH-1:0]] <= i_host_data;
    if (tx_push) tx_mem[tx_wptr_q[LGDEPTH-1:0]] <= {i_ftdi_be, i_ftdi_data};
  end

  // Pad enable is released immediately while reset is held.
  assign o_ftdi_data    = rx_mem[rx_rptr_q[LGDEPTH-1:0]];
  assign o_ftdi_data_oe = !i_ftdi_oe_n && i_reset_n;
  assign o_ftdi_rxf_n   = rxf_n_q;
  assign o_ftdi_txe_n   = txe_n_q;
  assign o_host_full    = host_full_q;
  assign o_host_data    = tx_mem[tx_rptr_q[LGDEPTH-1:0]];
  assign o_host_empty   = host_empty_q;
  assign o_rx_count     = rx_count_q;
  assign o_tx_count     = tx_count_q;
  assign o_protocol_err = proto_err_q;

endmodule

// File: tb/tb_ft601_fifo_responder.sv
// Self-checking bench for ft601_fifo_responder: vector table for the basic RX read,
// queue scoreboards for TX fill/drain, RX pointer wrap, protocol error and mid-burst reset.
module tb_ft601_fifo_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_n, rd_n, oe_n;
  logic [31:0] f_din;
  logic [3:0]  f_be;
  logic [31:0] f_dout;
  logic        f_doe, rxf_n, txe_n;
  logic        h_wr;
  logic [31:0] h_din;
  logic        h_full;
  logic        h_rd;
  logic [35:0] h_dout;
  logic        h_empty;
  logic [4:0]  rx_cnt, tx_cnt;
  logic        perr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ft601_fifo_responder #(.LGDEPTH(4), .DW(32)) dut (
    .i_ftdi_clk(clk), .i_reset_n(rst_n),
    .i_ftdi_wr_n(wr_n), .i_ftdi_rd_n(rd_n), .i_ftdi_oe_n(oe_n),
    .i_ftdi_data(f_din), .i_ftdi_be(f_be),
    .o_ftdi_data(f_dout), .o_ftdi_data_oe(f_doe),
    .o_ftdi_rxf_n(rxf_n), .o_ftdi_txe_n(txe_n),
    .i_host_wr(h_wr), .i_host_data(h_din), .o_host_full(h_full),
    .i_host_rd(h_rd), .o_host_data(h_dout), .o_host_empty(h_empty),
    .o_rx_count(rx_cnt), .o_tx_count(tx_cnt), .o_protocol_err(perr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        hwr;
    logic [31:0] hdata;
    logic        oe_n;
    logic        rd_n;
    logic [4:0]  exp_cnt;
    logic        exp_rxf_n;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_doe;
  } vec_t;

  vec_t vecs[10];
  logic [35:0] txq[$];
  logic [31:0] rxq[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mcount;
    logic [35:0] exp_tx;

    vecs[0] = '{1'b1, 32'h11, 1'b1, 1'b1, 5'd1, 1'b0, 1'b1, 32'h11, 1'b0};
    vecs[1] = '{1'b1, 32'h22, 1'b1, 1'b1, 5'd2, 1'b0, 1'b1, 32'h11, 1'b0};
    vecs[2] = '{1'b1, 32'h33, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 32'h11, 1'b0};
    vecs[3] = '{1'b0, 32'h0,  1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 32'h11, 1'b1};
    vecs[4] = '{1'b0, 32'h0,  1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 32'h11, 1'b1};
    vecs[5] = '{1'b0, 32'h0,  1'b0, 1'b0, 5'd2, 1'b0, 1'b1, 32'h22, 1'b1};
    vecs[6] = '{1'b0, 32'h0,  1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 32'h33, 1'b1};
    vecs[7] = '{1'b0, 32'h0,  1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0,  1'b1};
    vecs[8] = '{1'b0, 32'h0,  1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0,  1'b1};
    vecs[9] = '{1'b0, 32'h0,  1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 32'h0,  1'b0};

    rst_n = 1'b0; wr_n = 1'b1; rd_n = 1'b1; oe_n = 1'b1;
    f_din = 32'h0; f_be = 4'h0; h_wr = 1'b0; h_din = 32'h0; h_rd = 1'b0;
    tick(); tick();
    check("rst_rxf_n", rxf_n, 1'b1);
    check("rst_txe_n", txe_n, 1'b0);
    check("rst_doe", f_doe, 1'b0);
    check("rst_empty", h_empty, 1'b1);
    check("rst_full", h_full, 1'b0);
    check("rst_perr", perr, 1'b0);
    check("rst_rxcnt", rx_cnt, 5'd0);
    check("rst_txcnt", tx_cnt, 5'd0);
    rst_n = 1'b1;
    tick();

    // basic host push then bus read of 0x11,0x22,0x33
    for (int i = 0; i < 10; i++) begin
      h_wr = vecs[i].hwr; h_din = vecs[i].hdata;
      oe_n = vecs[i].oe_n; rd_n = vecs[i].rd_n;
      tick();
      check($sformatf("vec%0d_rxcnt", i), rx_cnt, vecs[i].exp_cnt);
      check($sformatf("vec%0d_rxf_n", i), rxf_n, vecs[i].exp_rxf_n);
      check($sformatf("vec%0d_doe", i), f_doe, vecs[i].exp_doe);
      if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), f_dout, vecs[i].exp_data);
      else                  check($sformatf("vec%0d_perr", i), perr, 1'b0);
    end

    // master writes 17 dwords; only 16 fit
    mcount = 0;
    for (int i = 0; i < 17; i++) begin
      wr_n = 1'b0; f_be = 4'hF; f_din = 32'hA0 + i;
      if (mcount < 16) begin
        txq.push_back({4'hF, 32'hA0 + i});
        mcount++;
      end
      tick();
      check($sformatf("tx_fill%0d_cnt", i), tx_cnt, mcount[4:0]);
      check($sformatf("tx_fill%0d_txe_n", i), txe_n, (mcount == 16) ? 1'b1 : 1'b0);
    end
    wr_n = 1'b1;
    tick();
    check("tx_full_perr", perr, 1'b0);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("tx_pop%0d_empty", i), h_empty, 1'b0);
      exp_tx = txq.pop_front();
      check($sformatf("tx_pop%0d_data", i), h_dout, exp_tx);
      h_rd = 1'b1;
      tick();
    end
    h_rd = 1'b0;
    check("tx_drained_empty", h_empty, 1'b1);
    check("tx_drained_txe_n", txe_n, 1'b0);
    check("tx_drained_cnt", tx_cnt, 5'd0);

    // simultaneous push and pop across pointer wrap
    for (int k = 0; k < 5; k++) begin
      h_wr = 1'b1; h_din = 32'hC000_0000 + k;
      rxq.push_back(h_din);
      tick();
    end
    h_wr = 1'b0;
    check("wrap_pre_cnt", rx_cnt, 5'd5);
    oe_n = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      h_wr = 1'b1; h_din = 32'hD000_0000 + i; rd_n = 1'b0;
      check($sformatf("wrap%0d_data", i), f_dout, rxq[0]);
      tick();
      void'(rxq.pop_front());
      rxq.push_back(h_din);
      check($sformatf("wrap%0d_cnt", i), rx_cnt, 5'd5);
    end
    h_wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain%0d_data", i), f_dout, rxq[0]);
      tick();
      void'(rxq.pop_front());
    end
    check("drain_rxf_n", rxf_n, 1'b1);
    check("drain_cnt", rx_cnt, 5'd0);
    tick();
    check("drain_hold_cnt", rx_cnt, 5'd0);
    rd_n = 1'b1; oe_n = 1'b1;
    tick();
    check("wrap_perr", perr, 1'b0);

    // rd_n and wr_n together: error, no transfer, sticky until reset
    h_wr = 1'b1; h_din = 32'h77;
    tick();
    h_wr = 1'b0;
    rd_n = 1'b0; wr_n = 1'b0; f_din = 32'h99;
    tick();
    check("perr_set", perr, 1'b1);
    check("perr_no_push", tx_cnt, 5'd0);
    check("perr_no_pop", rx_cnt, 5'd1);
    rd_n = 1'b1; wr_n = 1'b1;
    tick(); tick();
    check("perr_held", perr, 1'b1);
    wr_n = 1'b0; f_din = 32'h55;
    tick();
    wr_n = 1'b1;
    check("perr_later_push", tx_cnt, 5'd1);
    check("perr_still_held", perr, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("perr_cleared", perr, 1'b0);
    check("perr_rst_txcnt", tx_cnt, 5'd0);
    check("perr_rst_rxcnt", rx_cnt, 5'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // reset in the middle of an RX burst with 8 queued
    for (int k = 0; k < 10; k++) begin
      h_wr = 1'b1; h_din = 32'hE0 + k;
      tick();
    end
    h_wr = 1'b0; oe_n = 1'b0;
    tick(); tick();
    rd_n = 1'b0;
    tick();
    check("burst_pop1_data", f_dout, 32'hE1);
    tick();
    check("burst_cnt8", rx_cnt, 5'd8);
    check("burst_doe", f_doe, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_rxcnt", rx_cnt, 5'd0);
    check("mrst_rxf_n", rxf_n, 1'b1);
    check("mrst_doe", f_doe, 1'b0);
    check("mrst_empty", h_empty, 1'b1);
    check("mrst_txe_n", txe_n, 1'b0);
    rd_n = 1'b1; oe_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_rxcnt", rx_cnt, 5'd0);
    check("post_rst_perr", perr, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
